// File: rtl/ex_div_iter_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM encodings and
// the slot this unit occupies on the CTRL stall-request bus.
package ex_div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Width of the CTRL stall-request bus and this divider's bit within it
    localparam int STALL_W       = 6;
    localparam int STALL_IDX_DIV = 3;

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial remainder,
// trial-subtract the divisor, keep the difference when it is non-negative.
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_shift_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    // One extra bit of headroom so the sign of the trial difference is exact
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;

    assign w_shifted = {i_rem, i_shift_bit};
    assign w_diff    = w_shifted - {2'b00, i_divisor};
    assign o_q_bit   = ~w_diff[WIDTH+1];
    assign o_rem     = o_q_bit ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];

endmodule

// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider for the EX stage, signed/unsigned, with
// flush cancel. Define EX_DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle.
module ex_div_iter
    import ex_div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             busy,
    output logic             stallreq,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dq;       // dividend magnitude, refilled with quotient bits
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_div_zero_in;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic             w_last;
    logic             w_stallreq;
    logic             w_ready;

    assign w_accept      = (r_state == DIV_IDLE) && start && !annul;
    assign w_div_zero_in = (divisor == '0);
    // Negating the most-negative value yields itself, which is the right magnitude unsigned
    assign w_dvd_mag     = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag     = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign w_last        = (r_cnt == CNT_W'(1));

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem       (r_rem),
        .i_shift_bit (r_dq[WIDTH-1]),
        .i_divisor   (r_dvs),
        .o_rem       (w_rem_next),
        .o_q_bit     (w_q_bit)
    );

    assign w_q_final = {r_dq[WIDTH-2:0], w_q_bit};
    assign w_r_final = w_rem_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stallreq   = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_stallreq = 1'b1;
`ifdef EX_DIV_ZERO_FAST_EN
                    w_state_next = w_div_zero_in ? DIV_DONE : DIV_RUN;
`else
                    w_state_next = DIV_RUN;
`endif
                end
            end
            DIV_RUN: begin
                w_stallreq = 1'b1;
                if (annul) begin
                    w_state_next = DIV_IDLE;
                end else if (w_last) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_ready      = !annul;
                w_state_next = DIV_IDLE;
            end
            default: begin
                w_state_next = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_neg_q <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r <= signed_div && dividend[WIDTH-1];
                        r_zero  <= w_div_zero_in;
                        r_dq    <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
`ifdef EX_DIV_ZERO_FAST_EN
                        if (w_div_zero_in) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_cnt       <= '0;
                        end
`endif
                    end
                end
                DIV_RUN: begin
                    if (annul) begin
                        r_cnt <= '0;
                    end else begin
                        r_dq  <= w_q_final;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            // Divide by zero reports all ones regardless of operand signs
                            r_quotient  <= r_zero  ? '1 : (r_neg_q ? -w_q_final : w_q_final);
                            r_remainder <= r_neg_r ? -w_r_final : w_r_final;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != DIV_IDLE);
    assign stallreq  = w_stallreq;
    assign ready     = w_ready;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_ex_div_iter.sv
// Directed bench for ex_div_iter (WIDTH=32): table of divide vectors plus
// hand-written sequences for annul, held start, reset mid-run and start+annul.
module tb_ex_div_iter;

    localparam int W = 32;
`ifdef EX_DIV_ZERO_FAST_EN
    localparam int ZL = 1;
`else
    localparam int ZL = 33;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         annul;
    logic         busy;
    logic         stallreq;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

    ex_div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .busy       (busy),
        .stallreq   (stallreq),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int           exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one divide and wait for ready; lat counts cycles after the accept edge.
    // With hold set, start stays high with other operands during the run.
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hold, output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output logic ctl_ok);
        ctl_ok = 1'b1;
        lat    = 0;
        q      = '0;
        r      = '0;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; dividend = a; divisor = b;
        #1;
        if (stallreq !== 1'b1 || busy !== 1'b0) ctl_ok = 1'b0;
        @(posedge clk);
        #1;
        if (hold) begin
            signed_div = 1'b0; dividend = 32'd9; divisor = 32'd3;
        end else begin
            start = 1'b0;
        end
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                q   = quotient;
                r   = remainder;
                if (stallreq !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
                break;
            end
            if (stallreq !== 1'b1 || busy !== 1'b1) ctl_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    logic [W-1:0] q, r;
    int           lat;
    logic         ok;
    int           ready_seen;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,      32'd7,      32'd14,     32'd2,      33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,      32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,    33};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,    33};
        vecs[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,    32'h80000000, 33};
        vecs[5]  = '{1'b0, 32'h1234,     32'd0,      32'hFFFFFFFF, 32'h1234,   ZL};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'd0,      32'hFFFFFFFF, 32'hFFFFFFF9, ZL};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1,      32'hFFFFFFFF, 32'd0,      33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,   32'hFFFFFFFE, 33};
        vecs[9]  = '{1'b0, 32'd5,        32'd10,     32'd0,      32'd5,      33};
        vecs[10] = '{1'b0, 32'hDEADBEEF, 32'h10000,  32'h0000DEAD, 32'h0000BEEF, 33};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_stallreq", {63'd0, stallreq}, 64'd0);
        check("reset_quotient", {32'd0, quotient}, 64'd0);
        check("reset_remainder", {32'd0, remainder}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, q, r, lat, ok);
            $display("[TB] vec %0d: s=%0b %h / %h -> q=%h r=%h lat=%0d ctl=%0b",
                     i, vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat, ok);
            check($sformatf("vec%0d_quotient", i), {32'd0, q}, {32'd0, vecs[i].exp_q});
            check($sformatf("vec%0d_remainder", i), {32'd0, r}, {32'd0, vecs[i].exp_r});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_stall_busy", i), {63'd0, ok}, 64'd1);
        end

        // annul at RUN cycle 10: results from the last vector must survive
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        ready_seen = 0;
        for (int n = 1; n < 10; n++) begin
            @(negedge clk);
            if (ready === 1'b1) ready_seen++;
        end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        $display("[TB] annul: busy=%0b ready=%0b q=%h r=%h", busy, ready, quotient, remainder);
        check("annul_busy", {63'd0, busy}, 64'd0);
        check("annul_ready", {63'd0, ready}, 64'd0);
        check("annul_no_early_ready", 64'(ready_seen), 64'd0);
        check("annul_quotient_kept", {32'd0, quotient}, 64'h0000DEAD);
        check("annul_remainder_kept", {32'd0, remainder}, 64'h0000BEEF);
        run_op(1'b0, 32'd50, 32'd5, 1'b0, q, r, lat, ok);
        $display("[TB] after annul: 50 / 5 -> q=%h r=%h lat=%0d", q, r, lat);
        check("post_annul_quotient", {32'd0, q}, 64'd10);
        check("post_annul_remainder", {32'd0, r}, 64'd0);
        check("post_annul_latency", 64'(lat), 64'd33);

        // start held through RUN with different operands must be ignored
        run_op(1'b0, 32'd100, 32'd7, 1'b1, q, r, lat, ok);
        $display("[TB] held start: q=%h r=%h lat=%0d", q, r, lat);
        check("held_start_quotient", {32'd0, q}, 64'd14);
        check("held_start_remainder", {32'd0, r}, 64'd2);
        check("held_start_latency", 64'(lat), 64'd33);
        @(negedge clk);
        check("held_start_idle_after", {63'd0, busy}, 64'd0);

        // reset mid-run clears outputs and kills the operation
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] reset mid-run: busy=%0b q=%h r=%h", busy, quotient, remainder);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_quotient", {32'd0, quotient}, 64'd0);
        check("midrst_remainder", {32'd0, remainder}, 64'd0);
        ready_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready === 1'b1) ready_seen++;
        end
        check("midrst_no_ready", 64'(ready_seen), 64'd0);

        // start together with annul in IDLE is dropped
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dividend = 32'd8; divisor = 32'd2;
        #1;
        check("start_annul_stallreq", {63'd0, stallreq}, 64'd0);
        @(posedge clk);
        #1 start = 1'b0; annul = 1'b0;
        $display("[TB] start+annul: busy=%0b", busy);
        check("start_annul_busy", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
